// File: rtl/dac_spi_pkg.sv
// Shared types and frame-layout helpers for the AD978x-class SPI register controller.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT,
    ST_IDLE,
    ST_XFER,
    ST_RB
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DATA_LSB = 0;

  // Frame is {rw, 2'b00, addr, data}, MSB first.
  function automatic int frame_w(input int aw, input int dw);
    return 3 + aw + dw;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rw_pos(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// One full-duplex SPI frame: owns CS framing, SCK divider and the inter-frame CS-high gap.
module spi_shift_engine #(
  parameter int N_DEV   = 2,
  parameter int FRAME_W = 16,
  parameter int RX_W    = 8,
  parameter int SCK_DIV = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [N_DEV-1:0]   dev_oh_in,
  input  logic [FRAME_W-1:0] tx_in,
  output logic               ready_out,
  output logic               done_out,
  output logic [RX_W-1:0]    rx_out,
  output logic [N_DEV-1:0]   cs_n_out,
  output logic               sck_out,
  output logic               sdo_out,
  input  logic               sdi_in
);

  localparam int DW = $clog2(2*SCK_DIV + 1);
  localparam int PW = $clog2(2*FRAME_W + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(2*SCK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*FRAME_W);

  logic               act_q, act_d, gap_q, gap_d, done_q, done_d;
  logic               sck_q, sck_d, sdo_q, sdo_d;
  logic [DW-1:0]      div_q, div_d;
  logic [PW-1:0]      ph_q, ph_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [RX_W-1:0]    rx_q, rx_d;
  logic [N_DEV-1:0]   cs_n_q, cs_n_d;

  // Phase 0 is the lead-in before the first rise; odd phases are SCK high,
  // even phases SCK low, and the final even phase is the CS hold-off.
  always_comb begin
    act_d  = act_q;
    gap_d  = gap_q;
    done_d = 1'b0;
    sck_d  = sck_q;
    sdo_d  = sdo_q;
    div_d  = div_q;
    ph_d   = ph_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    cs_n_d = cs_n_q;
    if (act_q) begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (ph_q == PH_LAST) begin
          act_d  = 1'b0;
          gap_d  = 1'b1;
          done_d = 1'b1;
          cs_n_d = '1;
          sdo_d  = 1'b0;
        end else begin
          ph_d = ph_q + 1'b1;
          if (!ph_q[0]) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[RX_W-2:0], sdi_in};
          end else begin
            sck_d = 1'b0;
            sdo_d = sh_q[FRAME_W-1];
            sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end else if (gap_q) begin
      div_d = div_q + 1'b1;
      if (div_q == GAP_LAST) begin
        gap_d = 1'b0;
        div_d = '0;
      end
    end else if (start_in) begin
      act_d  = 1'b1;
      cs_n_d = ~dev_oh_in;
      sdo_d  = tx_in[FRAME_W-1];
      sh_d   = {tx_in[FRAME_W-2:0], 1'b0};
      ph_d   = '0;
      div_d  = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      act_q  <= 1'b0;
      gap_q  <= 1'b0;
      done_q <= 1'b0;
      sck_q  <= 1'b0;
      sdo_q  <= 1'b0;
      div_q  <= '0;
      ph_q   <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
      cs_n_q <= '1;
    end else begin
      act_q  <= act_d;
      gap_q  <= gap_d;
      done_q <= done_d;
      sck_q  <= sck_d;
      sdo_q  <= sdo_d;
      div_q  <= div_d;
      ph_q   <= ph_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      cs_n_q <= cs_n_d;
    end
  end

  assign ready_out = !act_q && !gap_q;
  assign done_out  = done_q;
  assign rx_out    = rx_q;
  assign cs_n_out  = cs_n_q;
  assign sck_out   = sck_q;
  assign sdo_out   = sdo_q;

endmodule

// File: rtl/dac_spi_ctrl.sv
// DAC SPI register controller: reset pulse, init replay, queued host get/set commands.
// Optional DAC_SPI_READBACK_EN: every host write is verified by a read of the same register.
module dac_spi_ctrl
  import dac_spi_pkg::*;
#(
  parameter int N_DEV      = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int SCK_DIV    = 5,
  parameter int RST_CYCLES = 255,
  parameter int INIT_LEN   = 1,
  parameter logic [((INIT_LEN > 0) ? INIT_LEN : 1)*(ADDR_W+DATA_W)-1:0] INIT_WORDS = {5'h05, 8'h00},
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic              cmd_rw_in,
  input  logic [2:0]        cmd_dev_in,
  input  logic [ADDR_W-1:0] cmd_addr_in,
  input  logic [DATA_W-1:0] cmd_data_in,
  output logic              rsp_valid_out,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic              err_out,
  output logic              busy_out,
  output logic              init_done_out,
  output logic              dac_rst_out,
  output logic [N_DEV-1:0]  spi_cs_n_out,
  output logic              spi_sck_out,
  output logic              spi_sdo_out,
  input  logic              spi_sdi_in
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int EW      = ADDR_W + DATA_W;
  localparam int IL      = (INIT_LEN > 0) ? INIT_LEN : 1;
  localparam int EIW     = $clog2(IL + 1);
  localparam int CW      = 4 + ADDR_W + DATA_W;
  localparam int FAW     = $clog2(FIFO_DEPTH);
  localparam int RCW     = $clog2(RST_CYCLES + 1);

  state_e            state_q, state_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [EIW-1:0]    ent_q, ent_d;
  logic [2:0]        idev_q, idev_d;
  logic              init_done_q, init_done_d, dac_rst_q, dac_rst_d;
  logic              cur_rw_q, cur_rw_d, rb_q, rb_d;
  logic [2:0]        cur_dev_q, cur_dev_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic              rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [FAW:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     mem_q [FIFO_DEPTH];

  logic              empty, full, push, pop;
  logic [CW-1:0]     head;
  logic [EW-1:0]     init_ent;
  logic              sel_rw;
  logic [2:0]        sel_dev;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              eng_start, eng_ready, eng_done;
  logic [FRAME_W-1:0] eng_tx;
  logic [N_DEV-1:0]  eng_oh;
  logic [DATA_W-1:0] eng_rx;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[FAW] != rp_q[FAW]) && (wp_q[FAW-1:0] == rp_q[FAW-1:0]);
  assign push     = cmd_valid_in && !full;
  assign head     = mem_q[rp_q[FAW-1:0]];
  assign init_ent = INIT_WORDS[int'(ent_q)*EW +: EW];
  assign eng_tx   = {sel_rw, 2'b00, sel_addr, (sel_rw == RW_READ) ? {DATA_W{1'b0}} : sel_data};
  assign eng_oh   = N_DEV'(1) << sel_dev;

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wp_q[FAW-1:0]] <= {cmd_rw_in, cmd_dev_in, cmd_addr_in, cmd_data_in};
  end

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    ent_d       = ent_q;
    idev_d      = idev_q;
    init_done_d = init_done_q;
    dac_rst_d   = dac_rst_q;
    cur_rw_d    = cur_rw_q;
    cur_dev_d   = cur_dev_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    rb_d        = rb_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;
    pop         = 1'b0;
    eng_start   = 1'b0;
    sel_rw      = cur_rw_q;
    sel_dev     = cur_dev_q;
    sel_addr    = cur_addr_q;
    sel_data    = cur_data_q;
    case (state_q)
      ST_RST: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          dac_rst_d   = 1'b0;
          init_done_d = (INIT_LEN == 0);
          state_d     = (INIT_LEN > 0) ? ST_INIT : ST_IDLE;
        end
      end
      ST_INIT: begin
        sel_rw   = RW_WRITE;
        sel_dev  = idev_q;
        sel_addr = init_ent[DATA_W +: ADDR_W];
        sel_data = init_ent[DATA_LSB +: DATA_W];
        if (eng_ready) begin
          eng_start = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_IDLE: begin
        sel_rw   = head[CW-1];
        sel_dev  = head[CW-2 -: 3];
        sel_addr = head[addr_lsb(DATA_W) +: ADDR_W];
        sel_data = head[DATA_LSB +: DATA_W];
        if (!empty) begin
          if (int'(sel_dev) >= N_DEV) begin
            pop   = 1'b1;
            err_d = 1'b1;
          end else if (eng_ready) begin
            pop       = 1'b1;
            eng_start = 1'b1;
            state_d   = ST_XFER;
          end
        end
      end
      ST_RB: begin
        sel_rw = RW_READ;
        if (eng_ready) begin
          eng_start = 1'b1;
          state_d   = ST_XFER;
        end
      end
      default: begin
        if (eng_done) begin
          state_d = ST_IDLE;
          if (!init_done_q) begin
            // Init order is entry-major: every device gets entry k before entry k+1.
            if (idev_q == 3'(N_DEV - 1)) begin
              idev_d = '0;
              if (ent_q == EIW'(IL - 1)) init_done_d = 1'b1;
              else begin
                ent_d   = ent_q + 1'b1;
                state_d = ST_INIT;
              end
            end else begin
              idev_d  = idev_q + 1'b1;
              state_d = ST_INIT;
            end
          end else if (rb_q) begin
            rb_d = 1'b0;
            if (eng_rx != cur_data_q) begin
              err_d      = 1'b1;
              rsp_data_d = eng_rx;
            end
          end else if (cur_rw_q == RW_READ) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = eng_rx;
          end else begin
`ifdef DAC_SPI_READBACK_EN
            rb_d    = 1'b1;
            state_d = ST_RB;
`endif
          end
        end
      end
    endcase
    if (eng_start) begin
      cur_rw_d   = sel_rw;
      cur_dev_d  = sel_dev;
      cur_addr_d = sel_addr;
      cur_data_d = sel_data;
    end
    wp_d = wp_q + {{FAW{1'b0}}, push};
    rp_d = rp_q + {{FAW{1'b0}}, pop};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_RST;
      rcnt_q      <= '0;
      ent_q       <= '0;
      idev_q      <= '0;
      init_done_q <= 1'b0;
      dac_rst_q   <= 1'b1;
      cur_rw_q    <= 1'b0;
      cur_dev_q   <= '0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      rb_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      ent_q       <= ent_d;
      idev_q      <= idev_d;
      init_done_q <= init_done_d;
      dac_rst_q   <= dac_rst_d;
      cur_rw_q    <= cur_rw_d;
      cur_dev_q   <= cur_dev_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      rb_q        <= rb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
    end
  end

  spi_shift_engine #(
    .N_DEV(N_DEV), .FRAME_W(FRAME_W), .RX_W(DATA_W), .SCK_DIV(SCK_DIV)
  ) u_eng (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (eng_start),
    .dev_oh_in(eng_oh),
    .tx_in    (eng_tx),
    .ready_out(eng_ready),
    .done_out (eng_done),
    .rx_out   (eng_rx),
    .cs_n_out (spi_cs_n_out),
    .sck_out  (spi_sck_out),
    .sdo_out  (spi_sdo_out),
    .sdi_in   (spi_sdi_in)
  );

  assign cmd_ready_out = !full;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_data_out  = rsp_data_q;
  assign err_out       = err_q;
  assign init_done_out = init_done_q;
  assign dac_rst_out   = dac_rst_q;
  assign busy_out      = (state_q != ST_IDLE) || !empty || !eng_ready;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Directed bench for dac_spi_ctrl at default parameters; a pin monitor logs frames and pulses.
module tb_dac_spi_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       cmd_valid_in = 1'b0, cmd_ready_out, cmd_rw_in = 1'b0;
  logic [2:0] cmd_dev_in = '0;
  logic [4:0] cmd_addr_in = '0;
  logic [7:0] cmd_data_in = '0;
  logic       rsp_valid_out, err_out, busy_out, init_done_out, dac_rst_out;
  logic [7:0] rsp_data_out;
  logic [1:0] spi_cs_n_out;
  logic       spi_sck_out, spi_sdo_out;
  logic       spi_sdi_in = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  logic [15:0] fq_w[$];
  logic [1:0]  fq_cs[$];
  int          fq_r[$], fq_len[$], fq_gap[$];
  int          rsp_hi = 0, err_hi = 0, cs_multi = 0;
  logic [7:0]  model_val = 8'h00;

`ifdef DAC_SPI_READBACK_EN
  localparam int WR_FRAMES = 2;
`else
  localparam int WR_FRAMES = 1;
`endif

  dac_spi_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_rw_in(cmd_rw_in),
    .cmd_dev_in(cmd_dev_in), .cmd_addr_in(cmd_addr_in), .cmd_data_in(cmd_data_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .err_out(err_out),
    .busy_out(busy_out), .init_done_out(init_done_out), .dac_rst_out(dac_rst_out),
    .spi_cs_n_out(spi_cs_n_out), .spi_sck_out(spi_sck_out), .spi_sdo_out(spi_sdo_out),
    .spi_sdi_in(spi_sdi_in)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Pin monitor plus DAC SDI model (shifts out {8'h00, model_val} on SCK falls).
  initial begin
    logic        in_frm, sck_prev;
    logic [1:0]  cs_save;
    logic [15:0] w, sdi_sh;
    int          r, t0, t_end;
    in_frm = 0; sck_prev = 0; cs_save = '1; w = '0; sdi_sh = '0; r = 0; t0 = 0; t_end = 0;
    forever begin
      @(negedge clk_in);
      if (rsp_valid_out) rsp_hi++;
      if (err_out) err_hi++;
      if ($countones(~spi_cs_n_out) > 1) cs_multi++;
      if (!in_frm && spi_cs_n_out != 2'b11) begin
        in_frm = 1; t0 = cyc; cs_save = spi_cs_n_out; w = '0; r = 0;
        fq_gap.push_back(t0 - t_end);
        sdi_sh = {8'h00, model_val};
        spi_sdi_in = sdi_sh[15];
      end
      if (in_frm) begin
        if (spi_sck_out && !sck_prev) begin w = {w[14:0], spi_sdo_out}; r++; end
        if (!spi_sck_out && sck_prev) begin sdi_sh = {sdi_sh[14:0], 1'b0}; spi_sdi_in = sdi_sh[15]; end
        if (spi_cs_n_out == 2'b11) begin
          in_frm = 0; t_end = cyc;
          fq_w.push_back(w); fq_cs.push_back(cs_save); fq_r.push_back(r); fq_len.push_back(cyc - t0);
        end
      end
      sck_prev = spi_sck_out;
    end
  end

  task automatic clear_mon();
    fq_w.delete(); fq_cs.delete(); fq_r.delete(); fq_len.delete(); fq_gap.delete();
    rsp_hi = 0; err_hi = 0; cs_multi = 0;
  endtask

  task automatic issue(input logic rw, input logic [2:0] dev, input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk_in);
    cmd_valid_in = 1; cmd_rw_in = rw; cmd_dev_in = dev; cmd_addr_in = addr; cmd_data_in = data;
    @(negedge clk_in);
    cmd_valid_in = 0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    while ((busy_out || !init_done_out) && n < lim) begin @(negedge clk_in); n++; end
    total++;
    if (busy_out || !init_done_out) begin
      bad++; $display("FAIL %s_timeout: busy=%0b init_done=%0b after %0d cycles", nm, busy_out, init_done_out, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_in = 1;
    repeat (3) @(negedge clk_in);
    total++;
    if ({spi_cs_n_out, spi_sck_out, spi_sdo_out, dac_rst_out, rsp_valid_out, err_out, init_done_out, busy_out} !== 9'b11_0_0_1_0_0_0_1) begin
      bad++; $display("FAIL reset_pins: got %b want 110010001",
        {spi_cs_n_out, spi_sck_out, spi_sdo_out, dac_rst_out, rsp_valid_out, err_out, init_done_out, busy_out});
    end
    total++;
    if (rsp_data_out !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data_out); end
    rst_in = 0;
    clear_mon();
    n = 0;
    do begin @(posedge clk_in); #1; n++; end while (dac_rst_out && n < 1000);
    total++;
    if (n !== 255) begin bad++; $display("FAIL dac_rst_len: got %0d want 255", n); end
    wait_idle(3000, "init");
    total++;
    if (fq_w.size() !== 2 || fq_w[0] !== 16'h0500 || fq_w[1] !== 16'h0500) begin
      bad++; $display("FAIL init_frames: n=%0d w0=%h w1=%h want 2x0500", fq_w.size(), fq_w[0], fq_w[1]);
    end
    total++;
    if (fq_cs[0] !== 2'b10 || fq_cs[1] !== 2'b01) begin
      bad++; $display("FAIL init_cs_order: got %b,%b want 10,01", fq_cs[0], fq_cs[1]);
    end
    total++;
    if (init_done_out !== 1'b1) begin bad++; $display("FAIL init_done: got %b want 1", init_done_out); end
  endtask

  task automatic test_write();
    model_val = 8'hA5;
    clear_mon();
    issue(1'b0, 3'd1, 5'h02, 8'hA5);
    wait_idle(2000, "write");
    total++;
    if (fq_w.size() !== WR_FRAMES || fq_w[0] !== 16'h02A5) begin
      bad++; $display("FAIL write_frame: n=%0d w=%h want n=%0d w=02a5", fq_w.size(), fq_w[0], WR_FRAMES);
    end
    total++;
    if (fq_cs[0] !== 2'b01 || fq_r[0] !== 16 || fq_len[0] !== 165) begin
      bad++; $display("FAIL write_timing: cs=%b rises=%0d len=%0d want 01/16/165", fq_cs[0], fq_r[0], fq_len[0]);
    end
    total++;
    if (rsp_hi !== 0 || err_hi !== 0 || cs_multi !== 0) begin
      bad++; $display("FAIL write_side: rsp=%0d err=%0d multi=%0d want 0/0/0", rsp_hi, err_hi, cs_multi);
    end
  endtask

  task automatic test_read();
    model_val = 8'h3C;
    clear_mon();
    issue(1'b1, 3'd0, 5'h1F, 8'hEE);
    wait_idle(2000, "read");
    total++;
    if (fq_w.size() !== 1 || fq_w[0] !== 16'h9F00 || fq_cs[0] !== 2'b10) begin
      bad++; $display("FAIL read_frame: n=%0d w=%h cs=%b want 1/9f00/10", fq_w.size(), fq_w[0], fq_cs[0]);
    end
    total++;
    if (rsp_hi !== 1 || rsp_data_out !== 8'h3C) begin
      bad++; $display("FAIL read_rsp: pulses=%0d data=%h want 1/3c", rsp_hi, rsp_data_out);
    end
  endtask

  task automatic test_fifo_full();
    logic [15:0] exp_w[4];
    logic [1:0]  exp_cs[4];
    exp_w  = '{16'h8100, 16'h8200, 16'h8300, 16'h8400};
    exp_cs = '{2'b10, 2'b01, 2'b10, 2'b01};
    model_val = 8'h5A;
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      cmd_valid_in = 1; cmd_rw_in = 1; cmd_dev_in = 3'(i % 2); cmd_addr_in = 5'(i + 1); cmd_data_in = 8'h00;
      @(negedge clk_in);
      if (i == 2) begin
        total++;
        if (cmd_ready_out !== 1'b1) begin bad++; $display("FAIL fifo_ready_3: got %b want 1", cmd_ready_out); end
      end
      if (i == 3) begin
        total++;
        if (cmd_ready_out !== 1'b0) begin bad++; $display("FAIL fifo_ready_4: got %b want 0", cmd_ready_out); end
      end
    end
    cmd_valid_in = 0;
    wait_idle(5000, "fifo");
    total++;
    if (fq_w.size() !== 6) begin bad++; $display("FAIL fifo_frame_count: got %0d want 6", fq_w.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fq_w[i+2] !== exp_w[i] || fq_cs[i+2] !== exp_cs[i] || fq_gap[i+2] < 10) begin
        bad++; $display("FAIL fifo_frame_%0d: w=%h cs=%b gap=%0d want %h/%b/>=10",
          i, fq_w[i+2], fq_cs[i+2], fq_gap[i+2], exp_w[i], exp_cs[i]);
      end
    end
    total++;
    if (rsp_hi !== 4 || rsp_data_out !== 8'h5A || cs_multi !== 0) begin
      bad++; $display("FAIL fifo_rsp: pulses=%0d data=%h multi=%0d want 4/5a/0", rsp_hi, rsp_data_out, cs_multi);
    end
  endtask

  task automatic test_bad_dev_and_reset();
    clear_mon();
    issue(1'b1, 3'd5, 5'h01, 8'h00);
    repeat (20) @(negedge clk_in);
    total++;
    if (err_hi !== 1 || fq_w.size() !== 0 || spi_cs_n_out !== 2'b11 || busy_out !== 1'b0) begin
      bad++; $display("FAIL bad_dev: err=%0d frames=%0d cs=%b busy=%b want 1/0/11/0",
        err_hi, fq_w.size(), spi_cs_n_out, busy_out);
    end
    issue(1'b0, 3'd0, 5'h03, 8'h77);
    issue(1'b0, 3'd1, 5'h03, 8'h66);
    repeat (40) @(negedge clk_in);
    total++;
    if (spi_cs_n_out !== 2'b10) begin bad++; $display("FAIL mid_frame_cs: got %b want 10", spi_cs_n_out); end
    #2 rst_in = 1;
    #1;
    total++;
    if ({spi_cs_n_out, spi_sck_out, spi_sdo_out, dac_rst_out, init_done_out, busy_out} !== 7'b11_0_0_1_0_1) begin
      bad++; $display("FAIL async_reset: got %b want 1100101",
        {spi_cs_n_out, spi_sck_out, spi_sdo_out, dac_rst_out, init_done_out, busy_out});
    end
    @(negedge clk_in);
    rst_in = 0;
    clear_mon();
    wait_idle(3000, "reinit");
    total++;
    if (fq_w.size() !== 2 || fq_w[0] !== 16'h0500 || fq_w[1] !== 16'h0500) begin
      bad++; $display("FAIL reinit_flush: n=%0d w0=%h w1=%h want 2x0500", fq_w.size(), fq_w[0], fq_w[1]);
    end
  endtask

  task automatic test_readback();
    model_val = 8'h10;
    clear_mon();
    issue(1'b0, 3'd0, 5'h04, 8'h11);
    wait_idle(2000, "readback");
`ifdef DAC_SPI_READBACK_EN
    total++;
    if (fq_w.size() !== 2 || fq_w[0] !== 16'h0411 || fq_w[1] !== 16'h8400) begin
      bad++; $display("FAIL rb_frames: n=%0d w0=%h w1=%h want 2/0411/8400", fq_w.size(), fq_w[0], fq_w[1]);
    end
    total++;
    if (err_hi !== 1 || rsp_hi !== 0 || rsp_data_out !== 8'h10) begin
      bad++; $display("FAIL rb_mismatch: err=%0d rsp=%0d data=%h want 1/0/10", err_hi, rsp_hi, rsp_data_out);
    end
`else
    total++;
    if (fq_w.size() !== 1 || fq_w[0] !== 16'h0411 || err_hi !== 0 || rsp_hi !== 0) begin
      bad++; $display("FAIL write_no_rb: n=%0d w=%h err=%0d rsp=%0d want 1/0411/0/0",
        fq_w.size(), fq_w[0], err_hi, rsp_hi);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_bad_dev_and_reset();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
